// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared constants, FSM encoding and decode helpers for bus_controller
package bus_pkg;

  localparam logic [2:0] BHW_BYTE = 3'b001;
  localparam logic [2:0] BHW_HALF = 3'b010;
  localparam logic [2:0] BHW_WORD = 3'b100;

  localparam logic [31:0] RAM_BASE_DEF = 32'h0000_0000;
  localparam int          RAM_AW_DEF   = 14;
  localparam logic [31:0] PER_BASE_DEF = 32'h1000_0000;
  localparam int          PER_AW_DEF   = 12;
  localparam int          TIMEOUT_DEF  = 255;

  typedef enum logic [2:0] {
    IDLE,
    RAM_ACC,
    RAM_RD,
    PER_WAIT,
    RESP
  } state_t;

  function automatic logic bhw_legal(input logic [2:0] bhw);
    return (bhw == BHW_BYTE) || (bhw == BHW_HALF) || (bhw == BHW_WORD);
  endfunction

  // 33-bit compare so a region ending at 4 GiB cannot wrap
  function automatic logic in_region(input logic [31:0] addr, input logic [31:0] base,
                                     input logic [32:0] size);
    logic [32:0] a;
    logic [32:0] b;
    a = {1'b0, addr};
    b = {1'b0, base};
    return (a >= b) && (a < (b + size));
  endfunction

endpackage

// File: rtl/bus_if.sv
// rtl/bus_if.sv - CPU request/response, RAM and peripheral signal bundle for bus_controller
interface bus_if #(
  parameter int RAM_AW = bus_pkg::RAM_AW_DEF,
  parameter int PER_AW = bus_pkg::PER_AW_DEF
);

  logic [31:0]       i_cpu_address;
  logic [31:0]       i_cpu_data;
  logic [2:0]        i_cpu_bhw;
  logic              i_cpu_write_notread;
  logic              i_cpu_DV;
  logic [31:0]       o_cpu_data;
  logic              o_cpu_DV;
  logic              o_bus_error;
  logic              o_busy;

  logic              o_ram_en;
  logic [3:0]        o_ram_we;
  logic [RAM_AW-1:0] o_ram_addr;
  logic [31:0]       o_ram_wdata;
  logic [31:0]       i_ram_rdata;

  logic              o_per_req;
  logic              o_per_we;
  logic [PER_AW-1:0] o_per_addr;
  logic [31:0]       o_per_wdata;
  logic [3:0]        o_per_be;
  logic              i_per_ack;
  logic [31:0]       i_per_rdata;

  modport master (
    input  i_cpu_address, i_cpu_data, i_cpu_bhw, i_cpu_write_notread, i_cpu_DV,
    output o_cpu_data, o_cpu_DV, o_bus_error, o_busy,
    output o_ram_en, o_ram_we, o_ram_addr, o_ram_wdata,
    input  i_ram_rdata,
    output o_per_req, o_per_we, o_per_addr, o_per_wdata, o_per_be,
    input  i_per_ack, i_per_rdata
  );

  modport slave (
    output i_cpu_address, i_cpu_data, i_cpu_bhw, i_cpu_write_notread, i_cpu_DV,
    input  o_cpu_data, o_cpu_DV, o_bus_error, o_busy,
    input  o_ram_en, o_ram_we, o_ram_addr, o_ram_wdata,
    output i_ram_rdata,
    input  o_per_req, o_per_we, o_per_addr, o_per_wdata, o_per_be,
    output i_per_ack, i_per_rdata
  );

endinterface

// File: rtl/bus_lane_align.sv
// rtl/bus_lane_align.sv - byte-lane enables, write placement and read extraction by size and lane
module bus_lane_align
  import bus_pkg::*;
(
  input  logic [1:0]  lane,
  input  logic [2:0]  bhw,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_placed,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  always_comb begin
    be           = '0;
    wdata_placed = '0;
    rdata_ext    = '0;
    misaligned   = 1'b0;
    case (bhw)
      BHW_BYTE: begin
        be           = 4'b0001 << lane;
        wdata_placed = {4{wdata[7:0]}};
        rdata_ext    = {24'h0, rdata[{lane, 3'b000} +: 8]};
      end
      BHW_HALF: begin
        be           = lane[1] ? 4'b1100 : 4'b0011;
        wdata_placed = {2{wdata[15:0]}};
        rdata_ext    = {16'h0, (lane[1] ? rdata[31:16] : rdata[15:0])};
        misaligned   = lane[0];
      end
      BHW_WORD: begin
        be           = 4'b1111;
        wdata_placed = wdata;
        rdata_ext    = rdata;
        misaligned   = (lane != 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/bus_controller.sv
// rtl/bus_controller.sv - single-outstanding CPU bus controller routing to on-chip RAM or peripheral port
module bus_controller
  import bus_pkg::*;
#(
  parameter logic [31:0] RAM_BASE = RAM_BASE_DEF,
  parameter int          RAM_AW   = RAM_AW_DEF,
  parameter logic [31:0] PER_BASE = PER_BASE_DEF,
  parameter int          PER_AW   = PER_AW_DEF,
  parameter int          TIMEOUT  = TIMEOUT_DEF
) (
  input logic   i_clk,
  input logic   i_rst_n,
  bus_if.master bus
);

  localparam logic [32:0] RAM_SIZE = 33'd1 << (RAM_AW + 2);
  localparam logic [32:0] PER_SIZE = 33'd1 << PER_AW;
  localparam int          CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t            state, state_d;
  logic [1:0]        lane_q;
  logic [2:0]        bhw_q;
  logic [31:0]       data_q;
  logic              we_q;
  logic              err_q, err_d;
  logic [RAM_AW-1:0] ram_addr_q, ram_off;
  logic [PER_AW-1:0] per_addr_q, per_off;
  logic [CW-1:0]     cnt, cnt_d;
  logic [31:0]       cpu_data_q, cpu_data_d;

  logic              accept, in_ram, in_per, req_err;
  logic              ram_act, per_act;
  logic [1:0]        al_lane;
  logic [2:0]        al_bhw;
  logic [31:0]       al_rdata;
  logic [3:0]        be;
  logic [31:0]       wdata_pl, rdata_ext;
  logic              misaligned;

  assign accept  = (state == IDLE) && bus.i_cpu_DV;
  assign in_ram  = in_region(bus.i_cpu_address, RAM_BASE, RAM_SIZE);
  assign in_per  = in_region(bus.i_cpu_address, PER_BASE, PER_SIZE);
  assign ram_off = bus.i_cpu_address[RAM_AW+1:2] - RAM_BASE[RAM_AW+1:2];
  assign per_off = bus.i_cpu_address[PER_AW-1:0] - PER_BASE[PER_AW-1:0];

  // The aligner checks the live request in IDLE and serves the latched one afterwards
  assign al_lane  = (state == IDLE) ? bus.i_cpu_address[1:0] : lane_q;
  assign al_bhw   = (state == IDLE) ? bus.i_cpu_bhw : bhw_q;
  assign al_rdata = (state == RAM_RD) ? bus.i_ram_rdata : bus.i_per_rdata;
  assign req_err  = !bhw_legal(bus.i_cpu_bhw) || misaligned || !(in_ram || in_per);

  bus_lane_align u_align (
    .lane         (al_lane),
    .bhw          (al_bhw),
    .wdata        (data_q),
    .rdata        (al_rdata),
    .be           (be),
    .wdata_placed (wdata_pl),
    .rdata_ext    (rdata_ext),
    .misaligned   (misaligned)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      err_q      <= 1'b0;
      cpu_data_q <= '0;
      lane_q     <= '0;
      bhw_q      <= '0;
      data_q     <= '0;
      we_q       <= 1'b0;
      ram_addr_q <= '0;
      per_addr_q <= '0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      err_q      <= err_d;
      cpu_data_q <= cpu_data_d;
      if (accept) begin
        lane_q     <= bus.i_cpu_address[1:0];
        bhw_q      <= bus.i_cpu_bhw;
        data_q     <= bus.i_cpu_data;
        we_q       <= bus.i_cpu_write_notread;
        ram_addr_q <= ram_off;
        per_addr_q <= per_off;
      end
    end
  end

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    err_d      = err_q;
    cpu_data_d = cpu_data_q;
    case (state)
      IDLE: begin
        if (bus.i_cpu_DV) begin
          err_d = req_err;
          cnt_d = '0;
          // Errors borrow the RAM_ACC slot with ports gated, so they answer in cycle 2 like RAM writes
          state_d = (req_err || in_ram) ? RAM_ACC : PER_WAIT;
        end
      end
      RAM_ACC: begin
        if (err_q || we_q) begin
          state_d    = RESP;
          cpu_data_d = '0;
        end else begin
          state_d = RAM_RD;
        end
      end
      RAM_RD: begin
        state_d    = RESP;
        cpu_data_d = rdata_ext;
      end
      PER_WAIT: begin
        if (bus.i_per_ack) begin
          state_d    = RESP;
          cpu_data_d = we_q ? '0 : rdata_ext;
        end else if (cnt == CNT_LAST) begin
          state_d    = RESP;
          err_d      = 1'b1;
          cpu_data_d = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ram_act = (state == RAM_ACC) && !err_q;
  assign per_act = (state == PER_WAIT);

  assign bus.o_ram_en    = ram_act;
  assign bus.o_ram_we    = (ram_act && we_q) ? be : 4'b0000;
  assign bus.o_ram_addr  = ram_act ? ram_addr_q : '0;
  assign bus.o_ram_wdata = ram_act ? wdata_pl : '0;

  assign bus.o_per_req   = per_act;
  assign bus.o_per_we    = per_act && we_q;
  assign bus.o_per_addr  = per_act ? per_addr_q : '0;
  assign bus.o_per_wdata = per_act ? wdata_pl : '0;
  assign bus.o_per_be    = per_act ? be : 4'b0000;

  assign bus.o_cpu_data  = cpu_data_q;
  assign bus.o_cpu_DV    = (state == RESP);
  assign bus.o_bus_error = (state == RESP) && err_q;
  assign bus.o_busy      = (state != IDLE);

endmodule

// File: tb/tb_bus_controller.sv
// tb/tb_bus_controller.sv - directed plus randomized self-checking bench for bus_controller
module tb_bus_controller;
  import bus_pkg::*;

  localparam logic [31:0] PER_BASE = 32'h1000_0000;
  localparam int          TOUT     = 255;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  bus_if #(.RAM_AW(14), .PER_AW(12)) bus ();

  bus_controller #(
    .RAM_BASE (32'h0000_0000),
    .RAM_AW   (14),
    .PER_BASE (PER_BASE),
    .PER_AW   (12),
    .TIMEOUT  (TOUT)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Synchronous RAM device with registered read data
  logic [31:0] ram_mem [0:16383];
  always @(posedge clk) begin
    if (bus.o_ram_en) begin
      for (int b = 0; b < 4; b++)
        if (bus.o_ram_we[b]) ram_mem[bus.o_ram_addr][8*b +: 8] <= bus.o_ram_wdata[8*b +: 8];
      bus.i_ram_rdata <= ram_mem[bus.o_ram_addr];
    end
  end

  // Byte-addressed reference memory
  logic [7:0] ref_mem [int];

  function automatic logic [7:0] ref_byte(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one request at the current negedge, plays the peripheral, and checks the response.
  // ack_at: req cycle (1-based) carrying i_per_ack, 0 = never. spam: keep i_cpu_DV high while busy.
  task automatic xact(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] bhw,
                      input logic wr, input int ack_at, input logic [31:0] per_rd, input bit spam);
    int sz, lane, exp_lat, exp_ram, exp_per, cyc, lat, ram_cnt, per_cnt;
    bit legal, in_ram, in_per, err_exp, done, busy_bad, stable_bad;
    logic [31:0] exp_data, exp_be, exp_wd, seen_data, mask;
    logic seen_err, p_we;
    logic [3:0] r_we, p_be;
    logic [13:0] r_addr;
    logic [11:0] p_addr;
    logic [31:0] r_wd, p_wd;

    legal   = (bhw == 3'b001) || (bhw == 3'b010) || (bhw == 3'b100);
    sz      = (bhw == 3'b001) ? 1 : (bhw == 3'b010) ? 2 : 4;
    lane    = int'(addr % 4);
    in_ram  = addr < 32'h0001_0000;
    in_per  = (addr >= PER_BASE) && (addr < PER_BASE + 32'h1000);
    err_exp = !legal || ((addr % sz) != 0) || !(in_ram || in_per);
    exp_be  = ((32'd1 << sz) - 1) << lane;
    exp_wd  = (sz == 1) ? data[7:0] * 32'h0101_0101 : (sz == 2) ? data[15:0] * 32'h0001_0001 : data;
    mask    = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 1);
    exp_ram = 0; exp_per = 0; exp_data = 0;
    if (err_exp) exp_lat = 2;
    else if (in_ram) begin
      exp_ram = 1;
      exp_lat = wr ? 2 : 3;
      if (!wr) for (int i = 0; i < sz; i++) exp_data |= 32'(ref_byte(int'(addr) + i)) << (8 * i);
    end else if (ack_at >= 1 && ack_at <= TOUT) begin
      exp_per = ack_at;
      exp_lat = ack_at + 1;
      if (!wr) exp_data = (per_rd >> (8 * lane)) & mask;
    end else begin
      exp_per = TOUT;
      exp_lat = TOUT + 1;
      err_exp = 1;
    end

    bus.i_cpu_address = addr; bus.i_cpu_data = data; bus.i_cpu_bhw = bhw;
    bus.i_cpu_write_notread = wr; bus.i_cpu_DV = 1'b1;
    @(negedge clk);
    cyc = 1; done = 0; busy_bad = 0; stable_bad = 0; ram_cnt = 0; per_cnt = 0; lat = 0;
    seen_data = 0; seen_err = 0; r_we = 0; r_addr = 0; r_wd = 0; p_be = 0; p_addr = 0; p_wd = 0; p_we = 0;
    while (!done && cyc < 400) begin
      if (!bus.o_busy) busy_bad = 1;
      if (bus.o_ram_en) begin
        ram_cnt++; r_we = bus.o_ram_we; r_addr = bus.o_ram_addr; r_wd = bus.o_ram_wdata;
      end
      if (bus.o_per_req) begin
        per_cnt++;
        if (per_cnt == 1) begin
          p_be = bus.o_per_be; p_addr = bus.o_per_addr; p_wd = bus.o_per_wdata; p_we = bus.o_per_we;
        end else if (p_be !== bus.o_per_be || p_addr !== bus.o_per_addr ||
                     p_wd !== bus.o_per_wdata || p_we !== bus.o_per_we) stable_bad = 1;
      end
      if (bus.o_cpu_DV) begin
        done = 1; lat = cyc; seen_data = bus.o_cpu_data; seen_err = bus.o_bus_error;
      end
      bus.i_per_ack   = bus.o_per_req && (per_cnt == ack_at);
      bus.i_per_rdata = per_rd;
      if (spam) begin
        bus.i_cpu_address = 32'h0000_0020; bus.i_cpu_data = 32'hDEAD_BEEF;
        bus.i_cpu_bhw = BHW_WORD; bus.i_cpu_write_notread = 1'b1; bus.i_cpu_DV = 1'b1;
      end else bus.i_cpu_DV = 1'b0;
      if (!done) begin
        @(negedge clk);
        cyc++;
      end
    end
    check("resp_seen", 32'(done), 1);
    check("latency", lat, exp_lat);
    check("bus_error", 32'(seen_err), 32'(err_exp));
    check("rdata", seen_data, exp_data);
    check("busy_while_active", 32'(busy_bad), 0);
    check("ram_en_cycles", ram_cnt, exp_ram);
    check("per_req_cycles", per_cnt, exp_per);
    if (exp_ram != 0) begin
      check("ram_addr", 32'(r_addr), addr >> 2);
      check("ram_we", 32'(r_we), wr ? exp_be : 32'h0);
      if (wr) check("ram_wdata", r_wd, exp_wd);
    end
    if (per_cnt != 0 && in_per) begin
      check("per_addr", 32'(p_addr), addr - PER_BASE);
      check("per_be", 32'(p_be), exp_be);
      check("per_we", 32'(p_we), 32'(wr));
      check("per_stable", 32'(stable_bad), 0);
      if (wr) check("per_wdata", p_wd, exp_wd);
    end
    if (!err_exp && in_ram && wr)
      for (int i = 0; i < sz; i++) ref_mem[int'(addr) + i] = 8'((data >> (8 * i)) & 32'hFF);

    @(negedge clk);
    check("dv_single", 32'(bus.o_cpu_DV), 0);
    check("busy_after", 32'(bus.o_busy), 0);
    check("data_hold", bus.o_cpu_data, exp_data);
    bus.i_cpu_DV  = 1'b0;
    bus.i_per_ack = 1'b0;
  endtask

  initial begin
    int kind, ack, sz, n_dv;
    logic [31:0] a, d, prd;
    logic [2:0] b;
    bit wr, sp;

    bus.i_cpu_address = '0; bus.i_cpu_data = '0; bus.i_cpu_bhw = '0;
    bus.i_cpu_write_notread = 1'b0; bus.i_cpu_DV = 1'b0;
    bus.i_per_ack = 1'b0; bus.i_per_rdata = '0; bus.i_ram_rdata = '0;

    repeat (3) @(negedge clk);
    check("reset_dv", 32'(bus.o_cpu_DV), 0);
    check("reset_busy", 32'(bus.o_busy), 0);
    check("reset_err", 32'(bus.o_bus_error), 0);
    check("reset_data", bus.o_cpu_data, 0);
    check("reset_ram_en", 32'(bus.o_ram_en), 0);
    check("reset_per_req", 32'(bus.o_per_req), 0);
    rst_n = 1'b1;

    for (int w = 0; w < 64; w++) xact(32'(w * 4), $urandom, BHW_WORD, 1'b1, 0, 0, 1'b0);

    xact(32'h10, 32'hA1B2_C3D4, BHW_WORD, 1'b1, 0, 0, 1'b0);
    xact(32'h10, 32'h0, BHW_WORD, 1'b0, 0, 0, 1'b0);
    xact(32'h13, 32'h0000_0055, BHW_BYTE, 1'b1, 0, 0, 1'b0);
    xact(32'h10, 32'h0, BHW_WORD, 1'b0, 0, 0, 1'b0);
    check("sb_merge_model", {ref_byte(32'h13), ref_byte(32'h12), ref_byte(32'h11), ref_byte(32'h10)},
          32'h55B2_C3D4);
    xact(32'h12, 32'h0, BHW_BYTE, 1'b0, 0, 0, 1'b0);
    xact(32'h11, 32'h0, BHW_HALF, 1'b0, 0, 0, 1'b0);
    xact(32'h1000_0004, 32'h0, BHW_WORD, 1'b0, 5, 32'hCAFE_F00D, 1'b0);
    xact(32'h1000_0003, 32'h0, BHW_BYTE, 1'b0, 1, 32'h1122_3344, 1'b0);
    xact(32'h1000_0FFE, 32'h0000_BEEF, BHW_HALF, 1'b1, 3, 32'h0, 1'b0);
    xact(32'h1000_0100, 32'h0, BHW_WORD, 1'b0, TOUT, 32'h0BAD_CAFE, 1'b0);
    xact(32'h1000_0200, 32'h0, BHW_WORD, 1'b0, 0, 32'hFFFF_FFFF, 1'b0);
    xact(32'h10, 32'h0, BHW_WORD, 1'b0, 0, 0, 1'b0);
    xact(32'h14, 32'h0, BHW_WORD, 1'b0, 0, 0, 1'b1);
    xact(32'h20, 32'h0, BHW_WORD, 1'b0, 0, 0, 1'b0);
    xact(32'h0001_0000, 32'h0, BHW_WORD, 1'b0, 3, 0, 1'b0);
    xact(32'h0FFF_FFFC, 32'h0, BHW_WORD, 1'b1, 3, 0, 1'b0);
    xact(32'h1000_1000, 32'h0, BHW_BYTE, 1'b0, 3, 0, 1'b0);
    xact(32'h10, 32'h0, 3'b011, 1'b0, 0, 0, 1'b0);
    xact(32'h10, 32'h0, 3'b000, 1'b1, 0, 0, 1'b0);
    xact(32'h12, 32'h0, BHW_WORD, 1'b0, 0, 0, 1'b0);
    xact(32'h10, 32'h0, BHW_WORD, 1'b0, 0, 0, 1'b0);

    bus.i_cpu_address = 32'h1000_0008; bus.i_cpu_bhw = BHW_WORD;
    bus.i_cpu_write_notread = 1'b0; bus.i_cpu_DV = 1'b1;
    @(negedge clk);
    bus.i_cpu_DV = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_pre_req", 32'(bus.o_per_req), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_per_req", 32'(bus.o_per_req), 0);
    check("rst_per_be", 32'(bus.o_per_be), 0);
    check("rst_busy", 32'(bus.o_busy), 0);
    check("rst_dv", 32'(bus.o_cpu_DV), 0);
    check("rst_data", bus.o_cpu_data, 0);
    check("rst_err", 32'(bus.o_bus_error), 0);
    rst_n = 1'b1;
    n_dv = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.o_cpu_DV) n_dv++;
    end
    check("rst_no_resp", n_dv, 0);

    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 9);
      b    = 3'b001 << $urandom_range(0, 2);
      sz   = (b == 3'b001) ? 1 : (b == 3'b010) ? 2 : 4;
      wr   = 1'($urandom_range(0, 1));
      d    = $urandom;
      prd  = $urandom;
      ack  = $urandom_range(1, 6);
      sp   = ($urandom_range(0, 5) == 0);
      if (kind <= 5) begin
        a = $urandom_range(0, 255);
        if ($urandom_range(0, 4) != 0) a = a & ~32'(sz - 1);
      end else if (kind <= 7) begin
        a = PER_BASE + $urandom_range(0, 4095);
        if ($urandom_range(0, 4) != 0) a = a & ~32'(sz - 1);
      end else if (kind == 8) begin
        a = 32'h8000_0000 | $urandom;
      end else begin
        a = $urandom_range(0, 255);
        b = 3'($urandom_range(0, 7));
        while (b == 3'b001 || b == 3'b010 || b == 3'b100) b = 3'($urandom_range(0, 7));
      end
      xact(a, d, b, wr, ack, prd, sp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
